// File: rtl/axi4_pkg.sv
// Shared AXI4 types and the burst address helper for the SRAM responder.
package axi4_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RFETCH,
        ST_RDATA
    } slv_state_e;

    // Reserved burst type 2'b11 falls through to INCR stepping.
    function automatic logic [63:0] axi4_next_addr(input logic [63:0] addr, input logic [2:0] size,
                                                    input logic [7:0] len, input logic [1:0] burst);
        logic [63:0] step;
        logic [63:0] inc;
        logic [63:0] mask;
        step = 64'd1 << size;
        inc  = addr + step;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (addr & ~mask) | (inc & mask);
            default:     return inc;
        endcase
    endfunction

    function automatic logic axi4_illegal(input logic [2:0] size, input logic [7:0] len,
                                          input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == BURST_WRAP) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size > 3'd3) || (burst == 2'b11) || bad_wrap;
    endfunction

endpackage

// File: rtl/axi4_sram_slave_if.sv
// AXI4 channel bundle between one core master port and the SRAM responder.
interface axi4_sram_slave_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32
);
    logic              awvalid, awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wvalid, wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;
    logic              bvalid, bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rvalid, rready;
    logic [ID_W-1:0]   rid;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi4_addr_gen.sv
// Burst address/beat tracker shared by the write and read paths.
module axi4_addr_gen
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              rst_l,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_len,
    input  logic [2:0]        load_size,
    input  logic [1:0]        load_burst,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [7:0] beat_q;
    logic [7:0] len_q;
    logic [2:0] size_q;
    logic [1:0] burst_q;

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            addr    <= '0;
            beat_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
        end else if (load) begin
            addr    <= load_addr;
            beat_q  <= '0;
            len_q   <= load_len;
            size_q  <= load_size;
            burst_q <= load_burst;
        end else if (advance) begin
            addr   <= ADDR_W'(axi4_next_addr(64'(addr), size_q, len_q, burst_q));
            beat_q <= beat_q + 8'd1;
        end
    end

    assign last = (beat_q == len_q);
endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 responder into on-chip SRAM, one transaction in flight.
// Optional AXI_SLV_RANGE_CHECK_EN: out-of-window beats get DECERR instead of aliasing.
//   state     | meaning
//   ST_IDLE   | arbitrate AW/AR, latch request
//   ST_WDATA  | accept write beats
//   ST_WRESP  | hold write response until bready
//   ST_RFETCH | register SRAM word into rdata
//   ST_RDATA  | hold read beat until rready
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int              ID_W      = 4,
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 64,
    parameter int              MEM_DEPTH = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic             clock,
    input  logic             rst_l,
    axi4_sram_slave_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int NLANE = DATA_W / 8;

    slv_state_e        state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic              ill_q, prot_q, dec_q, prio_w_q;
    logic [DATA_W-1:0] rdata_q;
    resp_e             rresp_q;
    resp_e             wresp;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              grant_w, grant_r, w_fire, mem_we, oor;
    logic              ag_load, ag_adv, ag_last;
    logic [ADDR_W-1:0] ag_addr, ld_addr;
    logic [7:0]        ld_len;
    logic [2:0]        ld_size;
    logic [1:0]        ld_burst;
    logic [IDX_W-1:0]  idx;

    axi4_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clock      (clock),
        .rst_l      (rst_l),
        .load       (ag_load),
        .advance    (ag_adv),
        .load_addr  (ld_addr),
        .load_len   (ld_len),
        .load_size  (ld_size),
        .load_burst (ld_burst),
        .addr       (ag_addr),
        .last       (ag_last)
    );

    assign idx = IDX_W'((ag_addr - BASE_ADDR) >> 3);
`ifdef AXI_SLV_RANGE_CHECK_EN
    assign oor = ((ag_addr - BASE_ADDR) >> (IDX_W + 3)) != '0;
`else
    assign oor = 1'b0;
`endif

    // Round-robin: on contention the channel not granted last time wins.
    assign grant_w = bus.awvalid && (!bus.arvalid || prio_w_q);
    assign grant_r = bus.arvalid && !grant_w;
    assign w_fire  = (state_q == ST_WDATA) && bus.wvalid;
    assign mem_we  = w_fire && !ill_q && !oor;

    always_comb begin
        state_d  = state_q;
        ag_load  = 1'b0;
        ag_adv   = 1'b0;
        ld_addr  = grant_r ? bus.araddr  : bus.awaddr;
        ld_len   = grant_r ? bus.arlen   : bus.awlen;
        ld_size  = grant_r ? bus.arsize  : bus.awsize;
        ld_burst = grant_r ? bus.arburst : bus.awburst;
        case (state_q)
            ST_IDLE: begin
                if (grant_w) begin
                    ag_load = 1'b1;
                    state_d = ST_WDATA;
                end else if (grant_r) begin
                    ag_load = 1'b1;
                    state_d = ST_RFETCH;
                end
            end
            ST_WDATA: begin
                if (bus.wvalid) begin
                    if (ag_last) state_d = ST_WRESP;
                    else         ag_adv  = 1'b1;
                end
            end
            ST_WRESP:  if (bus.bready) state_d = ST_IDLE;
            ST_RFETCH: state_d = ST_RDATA;
            ST_RDATA: begin
                if (bus.rready) begin
                    if (ag_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        ag_adv  = 1'b1;
                        state_d = ST_RFETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            ill_q    <= 1'b0;
            prot_q   <= 1'b0;
            dec_q    <= 1'b0;
            prio_w_q <= 1'b1;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (ag_load) begin
                id_q     <= grant_w ? bus.awid : bus.arid;
                ill_q    <= axi4_illegal(ld_size, ld_len, ld_burst);
                prot_q   <= 1'b0;
                dec_q    <= 1'b0;
                prio_w_q <= !grant_w;
            end
            if (w_fire) begin
                if (bus.wlast != ag_last) prot_q <= 1'b1;
                if (oor)                  dec_q  <= 1'b1;
            end
            if (state_q == ST_RFETCH) begin
                rdata_q <= (ill_q || oor) ? '0 : mem[idx];
                rresp_q <= oor ? RESP_DECERR : (ill_q ? RESP_SLVERR : RESP_OKAY);
            end
        end
    end

    // SRAM array is deliberately left out of reset.
    always_ff @(posedge clock) begin
        for (int b = 0; b < NLANE; b++) begin
            if (mem_we && bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
    end

    assign wresp = dec_q ? RESP_DECERR : ((ill_q || prot_q) ? RESP_SLVERR : RESP_OKAY);

    assign bus.awready = rst_l && (state_q == ST_IDLE) && grant_w;
    assign bus.arready = rst_l && (state_q == ST_IDLE) && grant_r;
    assign bus.wready  = (state_q == ST_WDATA);
    assign bus.bvalid  = (state_q == ST_WRESP);
    assign bus.bid     = id_q;
    assign bus.bresp   = (state_q == ST_WRESP) ? wresp : RESP_OKAY;
    assign bus.rvalid  = (state_q == ST_RDATA);
    assign bus.rlast   = (state_q == ST_RDATA) && ag_last;
    assign bus.rid     = id_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: bursts, strobes, errors, arbitration, reset.
module tb_axi4_sram_slave;
    logic clock = 1'b0;
    logic rst_l = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] rq_data[$];
    logic [1:0]  rq_resp[$];
    logic        rq_last[$];
    logic [3:0]  rq_id[$];

    axi4_sram_slave_if #(.ID_W(4), .ADDR_W(32)) bus ();

    axi4_sram_slave #(
        .ID_W(4), .ADDR_W(32), .DATA_W(64), .MEM_DEPTH(4096), .BASE_ADDR(32'h0)
    ) dut (
        .clock (clock),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    task automatic aw_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit got = 0;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (bus.awready) got = 1;
        end
        if (!got) timeout("aw_handshake");
        @(posedge clock); #1;
        bus.awvalid = 1'b0;
    endtask

    task automatic ar_hs(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit got = 0;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (bus.arready) got = 1;
        end
        if (!got) timeout("ar_handshake");
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
    endtask

    task automatic w_beats(input logic [7:0] len, input logic [63:0] base, input logic [7:0] strb,
                           input int last_at, output int nbeats);
        nbeats = 0;
        for (int i = 0; i <= int'(len); i++) begin
            bit got = 0;
            bus.wvalid = 1'b1;
            bus.wdata  = base + 64'(i);
            bus.wstrb  = strb;
            bus.wlast  = (i == last_at);
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clock);
                if (bus.wready) got = 1;
            end
            if (!got) timeout("w_handshake");
            else nbeats++;
            @(posedge clock); #1;
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
    endtask

    task automatic b_wait(output logic [1:0] resp, output logic [3:0] id);
        bit got = 0;
        resp = 2'bxx;
        id   = 4'bxxxx;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clock);
            if (bus.bvalid) begin
                got  = 1;
                resp = bus.bresp;
                id   = bus.bid;
            end
        end
        if (!got) timeout("b_handshake");
        bus.bready = 1'b1;
        @(posedge clock); #1;
        bus.bready = 1'b0;
    endtask

    // With stall set, every beat is held off for one cycle before acceptance.
    task automatic r_collect(input logic [7:0] len, input bit stall, output int lat);
        int          nb = 0;
        bit          held = 0;
        logic [63:0] hdata = '0;
        lat = 0;
        rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_id.delete();
        bus.rready = !stall;
        for (int c = 1; c <= 200 && nb <= int'(len); c++) begin
            @(negedge clock);
            if (bus.rvalid) begin
                if (lat == 0) lat = c;
                if (bus.rready) begin
                    if (held) check("r_stable_stall", bus.rdata, hdata);
                    rq_data.push_back(bus.rdata);
                    rq_resp.push_back(bus.rresp);
                    rq_last.push_back(bus.rlast);
                    rq_id.push_back(bus.rid);
                    nb++;
                    held = 0;
                end else begin
                    held  = 1;
                    hdata = bus.rdata;
                end
            end
            @(posedge clock); #1;
            bus.rready = !stall || held;
        end
        if (nb <= int'(len)) timeout("r_beats");
        bus.rready = 1'b0;
    endtask

    initial begin
        logic [1:0] resp;
        logic [3:0] id;
        int         lat;
        int         nb;

        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        #12;
        check("rst_ready", 64'({bus.awready, bus.wready, bus.arready}), 64'd0);
        check("rst_valid", 64'({bus.bvalid, bus.rvalid, bus.rlast}), 64'd0);
        check("rst_resp", 64'({bus.bresp, bus.rresp}), 64'd0);
        check("rst_ids", 64'({bus.bid, bus.rid}), 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        @(posedge clock); #1;
        rst_l = 1'b1;
        @(posedge clock); #1;

        // single beat write then read
        aw_hs(4'h5, 32'h40, 8'd0, 3'd3, 2'b01);
        w_beats(8'd0, 64'h1122_3344_5566_7788, 8'hFF, 0, nb);
        b_wait(resp, id);
        check("single_bresp", 64'(resp), 64'd0);
        check("single_bid", 64'(id), 64'h5);
        ar_hs(4'h9, 32'h40, 8'd0, 3'd3, 2'b01);
        r_collect(8'd0, 1'b0, lat);
        check("single_latency", 64'(lat), 64'd2);
        check("single_rdata", rq_data[0], 64'h1122_3344_5566_7788);
        check("single_rlast", 64'(rq_last[0]), 64'd1);
        check("single_rresp", 64'(rq_resp[0]), 64'd0);
        check("single_rid", 64'(rq_id[0]), 64'h9);

        // INCR burst, read back with backpressure
        aw_hs(4'h1, 32'h100, 8'd3, 3'd3, 2'b01);
        w_beats(8'd3, 64'hA0, 8'hFF, 3, nb);
        b_wait(resp, id);
        check("incr_bresp", 64'(resp), 64'd0);
        ar_hs(4'h2, 32'h100, 8'd3, 3'd3, 2'b01);
        r_collect(8'd3, 1'b1, lat);
        check("incr_nbeats", 64'(rq_data.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("incr_rdata", rq_data[i], 64'hA0 + 64'(i));
            check("incr_rlast", 64'(rq_last[i]), 64'(i == 3));
        end

        // WRAP legal and illegal
        ar_hs(4'h3, 32'h118, 8'd3, 3'd3, 2'b10);
        r_collect(8'd3, 1'b0, lat);
        check("wrap_b0", rq_data[0], 64'hA3);
        check("wrap_b1", rq_data[1], 64'hA0);
        check("wrap_b2", rq_data[2], 64'hA1);
        check("wrap_b3", rq_data[3], 64'hA2);
        check("wrap_rresp", 64'(rq_resp[3]), 64'd0);
        ar_hs(4'h4, 32'h100, 8'd2, 3'd3, 2'b10);
        r_collect(8'd2, 1'b0, lat);
        check("wrap_bad_nbeats", 64'(rq_data.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check("wrap_bad_rresp", 64'(rq_resp[i]), 64'd2);
            check("wrap_bad_rdata", rq_data[i], 64'd0);
        end

        // partial strobe
        aw_hs(4'h6, 32'h200, 8'd0, 3'd3, 2'b01);
        w_beats(8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, nb);
        b_wait(resp, id);
        aw_hs(4'h6, 32'h200, 8'd0, 3'd3, 2'b01);
        w_beats(8'd0, 64'd0, 8'h0F, 0, nb);
        b_wait(resp, id);
        ar_hs(4'h6, 32'h200, 8'd0, 3'd3, 2'b01);
        r_collect(8'd0, 1'b0, lat);
        check("strobe_rdata", rq_data[0], 64'hFFFF_FFFF_0000_0000);

        // oversize transfer leaves memory alone
        aw_hs(4'h7, 32'h200, 8'd0, 3'd4, 2'b01);
        w_beats(8'd0, 64'h1234, 8'hFF, 0, nb);
        b_wait(resp, id);
        check("size4_bresp", 64'(resp), 64'd2);
        ar_hs(4'h7, 32'h200, 8'd0, 3'd3, 2'b01);
        r_collect(8'd0, 1'b0, lat);
        check("size4_mem", rq_data[0], 64'hFFFF_FFFF_0000_0000);

        // early wlast
        aw_hs(4'h8, 32'h300, 8'd3, 3'd3, 2'b01);
        w_beats(8'd3, 64'hB0, 8'hFF, 1, nb);
        b_wait(resp, id);
        check("early_wlast_beats", 64'(nb), 64'd4);
        check("early_wlast_bresp", 64'(resp), 64'd2);
        check("early_wlast_bid", 64'(id), 64'h8);

        // reset in the middle of a read burst
        ar_hs(4'hA, 32'h100, 8'd3, 3'd3, 2'b01);
        bus.rready = 1'b0;
        begin
            bit got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clock);
                if (bus.rvalid) got = 1;
            end
            if (!got) timeout("rst_mid_rvalid");
        end
        rst_l = 1'b0;
        #1;
        check("rst_mid_rvalid", 64'(bus.rvalid), 64'd0);
        @(posedge clock); #1;
        rst_l = 1'b1;
        @(posedge clock); #1;
        ar_hs(4'hB, 32'h108, 8'd0, 3'd3, 2'b01);
        r_collect(8'd0, 1'b0, lat);
        check("rst_mid_next_rdata", rq_data[0], 64'hA1);
        check("rst_mid_next_rid", 64'(rq_id[0]), 64'hB);

        // arbitration: simultaneous requests alternate AW then AR
        bus.arid = 4'h3; bus.araddr = 32'h40; bus.arlen = 0; bus.arsize = 3; bus.arburst = 2'b01;
        bus.awid = 4'h4; bus.awaddr = 32'h500; bus.awlen = 0; bus.awsize = 3; bus.awburst = 2'b01;
        bus.arvalid = 1'b1;
        bus.awvalid = 1'b1;
        @(negedge clock);
        check("arb1_grant", 64'({bus.awready, bus.arready}), 64'b10);
        @(posedge clock); #1;
        bus.awvalid = 1'b0;
        w_beats(8'd0, 64'h55, 8'hFF, 0, nb);
        bus.bready = 1'b1;
        begin
            bit got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clock);
                if (bus.bvalid) got = 1;
            end
            if (!got) timeout("arb1_b");
        end
        @(posedge clock); #1;
        bus.bready = 1'b0;
        bus.awaddr = 32'h508;
        bus.awvalid = 1'b1;
        @(negedge clock);
        check("arb2_grant", 64'({bus.awready, bus.arready}), 64'b01);
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        r_collect(8'd0, 1'b0, lat);
        check("arb2_rdata", rq_data[0], 64'h1122_3344_5566_7788);
        aw_hs(4'h4, 32'h508, 8'd0, 3'd3, 2'b01);
        w_beats(8'd0, 64'h66, 8'hFF, 0, nb);
        b_wait(resp, id);
        check("arb3_bresp", 64'(resp), 64'd0);
        ar_hs(4'h1, 32'h500, 8'd0, 3'd3, 2'b01);
        r_collect(8'd0, 1'b0, lat);
        check("arb1_mem", rq_data[0], 64'h55);

        // window check / aliasing
        aw_hs(4'h2, 32'h0, 8'd0, 3'd3, 2'b01);
        w_beats(8'd0, 64'hCAFE_F00D_1234_5678, 8'hFF, 0, nb);
        b_wait(resp, id);
        ar_hs(4'h2, 32'h8000, 8'd0, 3'd3, 2'b01);
        r_collect(8'd0, 1'b0, lat);
`ifdef AXI_SLV_RANGE_CHECK_EN
        check("range_rresp", 64'(rq_resp[0]), 64'd3);
        check("range_rdata", rq_data[0], 64'd0);
`else
        check("alias_rresp", 64'(rq_resp[0]), 64'd0);
        check("alias_rdata", rq_data[0], 64'hCAFE_F00D_1234_5678);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed time limit expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "time limit");
    end
endmodule
